// File: rtl/word_serializer.sv
// Serializes one W-bit word into W/DW strobed DW-bit beats, least-significant slice first,
// with GAP idle cycles between beats of the same word.
module word_serializer #(
  parameter int W   = 96,
  parameter int DW  = 32,
  parameter int GAP = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [W-1:0]  in_data,
  output logic          in_ready,
  output logic          en,
  output logic [DW-1:0] r,
  output logic          last,
  output logic          done
);

  localparam int N  = W / DW;
  localparam int BW = (N > 1) ? $clog2(N) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(N - 1);
  localparam logic [3:0]    GAP_LAST  = 4'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT
  } state_t;

  state_t          state_reg, state_next;
  logic [W-1:0]    shift_reg, shift_next;
  logic [BW-1:0]   beat_reg, beat_next;
  logic [BW-1:0]   beat_inc;
  logic [3:0]      gap_reg, gap_next;
  logic            in_ready_reg, in_ready_next;
  logic            en_reg, en_next;
  logic [DW-1:0]   r_reg, r_next;
  logic            last_reg, last_next;
  logic            done_reg, done_next;
  logic            advance;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      shift_reg    <= '0;
      beat_reg     <= '0;
      gap_reg      <= '0;
      in_ready_reg <= 1'b0;
      en_reg       <= 1'b0;
      r_reg        <= '0;
      last_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      shift_reg    <= shift_next;
      beat_reg     <= beat_next;
      gap_reg      <= gap_next;
      in_ready_reg <= in_ready_next;
      en_reg       <= en_next;
      r_reg        <= r_next;
      last_reg     <= last_next;
      done_reg     <= done_next;
    end
  end

  assign beat_inc = beat_reg + BW'(1);

  // Outputs are computed one cycle early so every port comes straight from a flop;
  // the state names the cycle the registered outputs currently describe.
  always_comb begin
    state_next    = state_reg;
    shift_next    = shift_reg;
    beat_next     = beat_reg;
    gap_next      = gap_reg;
    in_ready_next = in_ready_reg;
    en_next       = 1'b0;
    r_next        = r_reg;
    last_next     = 1'b0;
    done_next     = 1'b0;
    advance       = 1'b0;

    case (state_reg)
      IDLE: begin
        in_ready_next = 1'b1;
        if (in_valid && in_ready_reg) begin
          in_ready_next = 1'b0;
          en_next       = 1'b1;
          r_next        = in_data[DW-1:0];
          last_next     = (N == 1);
          shift_next    = in_data >> DW;
          beat_next     = '0;
          state_next    = SEND;
        end
      end
      SEND: begin
        if (beat_reg == LAST_BEAT) begin
          state_next    = IDLE;
          done_next     = 1'b1;
          in_ready_next = 1'b1;
        end else if (GAP == 0) begin
          advance = 1'b1;
        end else begin
          gap_next   = '0;
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (gap_reg == GAP_LAST) begin
          advance = 1'b1;
        end else begin
          gap_next = gap_reg + 4'd1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // Present the next slice; shift_reg already holds the remaining slices.
    if (advance) begin
      en_next    = 1'b1;
      r_next     = shift_reg[DW-1:0];
      last_next  = (beat_inc == LAST_BEAT);
      shift_next = shift_reg >> DW;
      beat_next  = beat_inc;
      state_next = SEND;
    end
  end

  assign in_ready = in_ready_reg;
  assign en       = en_reg;
  assign r        = r_reg;
  assign last     = last_reg;
  assign done     = done_reg;

endmodule

// File: tb/tb_word_serializer.sv
// Scoreboard bench: three serializer instances (defaults, GAP=0, N=1) checked against
// a cycle-formula reference model of beat timing, data and handshake.
module tb_word_serializer;

  logic             clk = 1'b0;
  logic             rst;
  logic [2:0]       v;
  logic [2:0][95:0] d;
  logic [2:0]       rdy, en_o, lst, dn;
  logic [2:0][31:0] rr;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    int          cyc;
    logic [31:0] data;
    logic        last;
  } beat_t;

  beat_t       bq[3][$];
  int          dq[3][$];
  int          rdy_cyc[3];
  logic [31:0] r_exp[3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  word_serializer #(.W(96), .DW(32), .GAP(1)) u_a (
    .clk(clk), .rst(rst), .in_valid(v[0]), .in_data(d[0]), .in_ready(rdy[0]),
    .en(en_o[0]), .r(rr[0]), .last(lst[0]), .done(dn[0]));

  word_serializer #(.W(96), .DW(32), .GAP(0)) u_b (
    .clk(clk), .rst(rst), .in_valid(v[1]), .in_data(d[1]), .in_ready(rdy[1]),
    .en(en_o[1]), .r(rr[1]), .last(lst[1]), .done(dn[1]));

  word_serializer #(.W(32), .DW(32), .GAP(1)) u_c (
    .clk(clk), .rst(rst), .in_valid(v[2]), .in_data(d[2][31:0]), .in_ready(rdy[2]),
    .en(en_o[2]), .r(rr[2]), .last(lst[2]), .done(dn[2]));

  function automatic int nb(input int i);
    return (i == 2) ? 1 : 3;
  endfunction

  function automatic int gp(input int i);
    return (i == 1) ? 0 : 1;
  endfunction

  task automatic chk(input string name, input int i, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s inst=%0d cyc=%0d got=%0h want=%0h", name, i, cyc, act, exp);
    end
  endtask

  // Reference model + monitor: beat k of a word accepted in cycle t is due in
  // cycle t+1+k*(GAP+1); done follows the last beat by one cycle.
  beat_t b;
  logic  m_rdy, exp_en, exp_dn;
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        bq[i].delete();
        dq[i].delete();
        rdy_cyc[i] = -1;
        r_exp[i]   = '0;
        chk("reset_outputs", i, {28'd0, rdy[i], en_o[i], lst[i], dn[i], rr[i]}, 64'd0);
      end else begin
        if (rdy_cyc[i] < 0) rdy_cyc[i] = cyc + 1;
        m_rdy = (cyc >= rdy_cyc[i]);
        chk("in_ready", i, {63'd0, rdy[i]}, {63'd0, m_rdy});
        exp_en = (bq[i].size() > 0) && (bq[i][0].cyc == cyc);
        chk("en", i, {63'd0, en_o[i]}, {63'd0, exp_en});
        if (exp_en) begin
          b = bq[i].pop_front();
          r_exp[i] = b.data;
          chk("last", i, {63'd0, lst[i]}, {63'd0, b.last});
        end else begin
          chk("last_idle", i, {63'd0, lst[i]}, 64'd0);
        end
        chk("r", i, {32'd0, rr[i]}, {32'd0, r_exp[i]});
        exp_dn = (dq[i].size() > 0) && (dq[i][0] == cyc);
        if (exp_dn) void'(dq[i].pop_front());
        chk("done", i, {63'd0, dn[i]}, {63'd0, exp_dn});
        if (v[i] && m_rdy) begin
          for (int k = 0; k < nb(i); k++) begin
            bq[i].push_back('{cyc: cyc + 1 + k * (gp(i) + 1),
                              data: d[i][k*32 +: 32],
                              last: (k == nb(i) - 1)});
          end
          dq[i].push_back(cyc + 2 + (nb(i) - 1) * (gp(i) + 1));
          rdy_cyc[i] = cyc + 2 + (nb(i) - 1) * (gp(i) + 1);
        end
      end
    end
  end

  // Holds in_valid until the word is taken, then drops it just after the accepting edge.
  task automatic send(input int i, input logic [95:0] w);
    int n;
    n = 0;
    v[i] = 1'b1;
    d[i] = w;
    do begin
      @(negedge clk);
      n++;
    end while (!(rdy[i] && !rst) && n < 50);
    if (!rdy[i]) begin
      total++;
      bad++;
      $display("FAIL send_timeout inst=%0d cyc=%0d got=%0d want=1", i, cyc, rdy[i]);
    end
    @(posedge clk);
    #1 v[i] = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst  = 1'b1;
    v    = 3'b111;
    d[0] = 96'h00000003_00000002_00000001;
    d[1] = {3{32'hCCCCCCCC}};
    d[2] = {64'd0, 32'hA5A5A5A5};
    idle(3);
    rst = 1'b0;
    idle(2);
    v[0] = 1'b0;
    v[2] = 1'b0;
    // instance b keeps in_valid high so B is taken in A's done cycle
    send(1, {3{32'hDDDDDDDD}});
    idle(8);

    // in_valid pulsed with junk while busy must be ignored
    send(0, 96'h89ABCDEF_01234567_0F1E2D3C);
    idle(1);
    v[0] = 1'b1;
    d[0] = '1;
    idle(1);
    v[0] = 1'b0;
    idle(8);

    // reset one cycle after beat 1
    send(0, 96'h11111111_22222222_33333333);
    idle(3);
    rst = 1'b1;
    #2;
    chk("async_reset", 0, {28'd0, rdy[0], en_o[0], lst[0], dn[0], rr[0]}, 64'd0);
    idle(1);
    rst = 1'b0;
    idle(2);
    send(0, 96'h44444444_55555555_66666666);
    idle(8);
    send(2, {64'd0, 32'h5A5A5A5A});
    idle(4);

    for (int t = 0; t < 60; t++) begin
      send($urandom_range(0, 2), {$urandom, $urandom, $urandom});
      idle($urandom_range(0, 3));
    end

    idle(20);
    for (int i = 0; i < 3; i++) begin
      chk("drain_beats", i, 64'(bq[i].size()), 64'd0);
      chk("drain_done", i, 64'(dq[i].size()), 64'd0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/word_serializer.md
# word_serializer

Transmit-side companion to the 32-bit accumulating datapath (`circuit`, W=96). It accepts one W-bit word over a valid/ready handshake and emits it as W/DW consecutive DW-bit beats on the `en`/`r` strobe interface that `circuit` consumes, least-significant slice first. A programmable number of idle cycles is inserted between beats. This reproduces the one-beat-every-other-cycle pacing used to drive `circuit`.

## Interface
- `W`, 96, width of the input word; must be a nonzero multiple of `DW`.
- `DW`, 32, beat width; N = W/DW beats per word.
- `GAP`, 1, idle cycles inserted between consecutive beats of one word (0..15).

- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  reset; asynchronous and active-high.
- `in_valid`  in  1  `in_data` holds a word to send.
- `in_data`  in  W  word to serialize.
- `in_ready`  out  1  block can accept a word this cycle.
- `en`  out  1  beat strobe, one cycle per beat.
- `r`  out  DW  beat data, valid when `en`=1.
- `last`  out  1  high with the final beat of a word.
- `done`  out  1  one-cycle pulse after the final beat.

## Operation
- All outputs are registered.
- Reset values: `in_ready`=0, `en`=0, `r`=0, `last`=0, `done`=0, state=IDLE.
- States:
  - IDLE:
    - `in_ready`=1.
    - When `in_valid`&`in_ready` is sampled at an edge, capture `in_data` into the shift register, clear the beat counter, clear `in_ready`, and go to SEND.
  - SEND (one cycle):
    - `en`=1, `r`=shift[DW-1:0], `last`=(beat==N-1).
    - At the edge: shift right by DW and increment beat.
    - If this was the last beat, go to IDLE with `done`=1 and `in_ready`=1.
    - Otherwise, if GAP=0, stay in SEND; else go to WAIT.
  - WAIT:
    - `en`=0, `last`=0.
    - Count GAP cycles, then go to SEND.
- No gap is inserted after the last beat.
- `r` holds its last driven value while `en`=0.
- `in_valid` is ignored whenever `in_ready`=0. A changing `in_data` mid-transaction must not affect emitted beats.
- Acceptance is allowed in the `done` cycle, so back-to-back words are sent with one idle cycle between them (the `done` cycle).
- `done` and `in_ready` may be high together. `done` is never high together with `en`.
- Reset mid-transaction:
  - All outputs drop to reset values immediately (asynchronously).
  - Remaining beats are discarded.
  - After `rst` deasserts, `in_ready` rises at the first rising edge.
- N=1 (W=DW) is legal: a single beat with `last`=1.

## Timing
- Cycle 0 is the cycle in which `in_valid`&`in_ready`=1 is sampled at the closing edge.
- Beat k (k=0..N-1) appears in cycle 1+k·(GAP+1).
- `last` accompanies beat N-1 in cycle 1+(N-1)(GAP+1).
- `done`=1 in cycle 2+(N-1)(GAP+1). The next word can be accepted in that same cycle.
- Default parameters (N=3, GAP=1):
  - Beats in cycles 1, 3, 5.
  - `done` in cycle 6.
  - Period between accepted words is 6 cycles.
- With GAP=0 the period is N+1 cycles.

## Test plan
- **Reset:** hold `rst`=1 for 3 cycles with `in_valid`=1.
  - Response: all outputs stay 0.
  - `in_ready`=1 after the first edge following release.
- **Single word, defaults:** `in_data`=0x00000003_00000002_00000001.
  - `en` high in cycles 1, 3, 5 with `r`=1, 2, 3.
  - `last`=1 only in cycle 5.
  - `done`=1 only in cycle 6.
- **Back-to-back, GAP=0:** `in_valid` held high with words A=0xCCCC…, then B=0xDDDD….
  - A's beats in cycles 1–3, `done` in cycle 4, B accepted in cycle 4.
  - B's beats in cycles 5–7.
  - Exactly one `en`=0 cycle between the two words.
- **Busy ignore:** during a transaction, pulse `in_valid` with `in_data`=0xFFFF…_FFFF.
  - The emitted beats equal the originally captured word.
  - `in_ready` stays 0 until `done`.
- **Reset mid-operation:** assert `rst` one cycle after beat 1.
  - `en`, `r`, `last`, `done` clear immediately.
  - No further beats appear.
  - The next word sends normally from beat 0.
- **N=1 (W=DW=32):** `in_data`=0xA5A5A5A5.
  - Cycle 1: `en`=1, `last`=1, `r`=0xA5A5A5A5.
  - Cycle 2: `done`=1.
